// File: rtl/mips_pkg.sv
// Shared loader state encoding, size defaults and byte-lane constants for the
// instruction loader and its helpers.
package mips_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 100;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    // Lane index of the byte that completes a word (big-endian: lane 0 is [31:24]).
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int depth);
        return (len != '0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface instr_loader_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [BYTE_W-1:0] Byte_In;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              IM_WE;
    logic [WIDTH-1:0]  IM_Addr;
    logic [WIDTH-1:0]  IM_WD;

    modport master (
        input  Byte_In,
        input  Byte_Valid,
        output Byte_Ready,
        output IM_WE,
        output IM_Addr,
        output IM_WD
    );

    modport slave (
        output Byte_In,
        output Byte_Valid,
        input  Byte_Ready,
        input  IM_WE,
        input  IM_Addr,
        input  IM_WD
    );

endinterface

// File: rtl/word_assembler.sv
// Packs a byte stream big-endian into words: shift register plus 2-bit byte
// counter, with a pulse on the byte that completes a word.
module word_assembler
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WIDTH-1:0]  word,
    output logic              word_done
);

    logic [WIDTH-1:0] word_reg, word_next;
    logic [1:0]       cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            word_reg <= word_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Shifting left by one byte puts the first byte of a word in the top lane.
    always_comb begin
        word_next = word_reg;
        cnt_next  = cnt_reg;
        if (clear) begin
            word_next = '0;
            cnt_next  = '0;
        end else if (shift_en) begin
            word_next = {word_reg[WIDTH-BYTE_W-1:0], byte_in};
            cnt_next  = cnt_reg + 2'd1;
        end
    end

    assign word      = word_reg;
    assign word_done = shift_en && !clear && (cnt_reg == LAST_LANE);

endmodule

// File: rtl/instr_loader.sv
// Loads a program byte stream into instruction memory and holds the core in
// reset until done. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module instr_loader
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [LEN_W-1:0] Load_Len,
    instr_loader_if.master   bus,
    output logic             CPU_RST,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    loader_state_t    state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic             clear;
    logic             xfer;
    logic             shift_en;
    logic             word_done;
    logic             last_word;
    logic [WIDTH-1:0] word;

`ifdef LOADER_CHECKSUM_EN
    logic              chk_reg, chk_next;
    logic [BYTE_W-1:0] xor_reg, xor_next;
`endif

    assign xfer      = bus.Byte_Valid && (state_reg == RECV);
    assign last_word = (idx_reg == (len_reg - LEN_W'(1)));

`ifdef LOADER_CHECKSUM_EN
    // The checksum byte is compared, never packed into a word.
    assign shift_en = xfer && !chk_reg;
`else
    assign shift_en = xfer;
`endif

    word_assembler #(
        .WIDTH(WIDTH)
    ) u_word_assembler (
        .clk      (CLK),
        .rst_n    (RST),
        .clear    (clear),
        .shift_en (shift_en),
        .byte_in  (bus.Byte_In),
        .word     (word),
        .word_done(word_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_reg   <= 1'b0;
            xor_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
`ifdef LOADER_CHECKSUM_EN
            chk_reg   <= chk_next;
            xor_reg   <= xor_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        clear      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_next   = chk_reg;
        xor_next   = xor_reg;
`endif
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    if (len_ok(Load_Len, DEPTH)) begin
                        state_next = RECV;
                        len_next   = Load_Len;
                        idx_next   = '0;
                        clear      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        chk_next   = 1'b0;
                        xor_next   = '0;
`endif
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            RECV: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    if (chk_reg) begin
                        state_next = (bus.Byte_In == xor_reg) ? DONE : ERR;
                    end else begin
                        xor_next = xor_reg ^ bus.Byte_In;
                        if (word_done) state_next = WRITE;
                    end
`else
                    if (word_done) state_next = WRITE;
`endif
                end
            end
            WRITE: begin
                // Index only advances when another word follows, so it stays <= DEPTH-1.
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = RECV;
                    chk_next   = 1'b1;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = RECV;
                    idx_next   = idx_reg + LEN_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.Byte_Ready = (state_reg == RECV);
    assign bus.IM_WE      = (state_reg == WRITE);
    assign bus.IM_Addr    = (state_reg == WRITE) ? (WIDTH'(idx_reg) << 2) : '0;
    assign bus.IM_WD      = (state_reg == WRITE) ? word : '0;

    assign Busy    = (state_reg == RECV) || (state_reg == WRITE);
    assign Done    = (state_reg == DONE);
    assign Error   = (state_reg == ERR);
    assign CPU_RST = (state_reg == DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; also exercises the
// LOADER_CHECKSUM_EN build when that macro is defined.
module tb_instr_loader;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Load_Len = '0;
    logic        CPU_RST, Busy, Done, Error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int base;

    instr_loader_if #(.WIDTH(32)) bus ();

    instr_loader #(
        .WIDTH(32),
        .DEPTH(100)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Load_Len(Load_Len),
        .bus     (bus),
        .CPU_RST (CPU_RST),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.IM_WE === 1'b1) begin
            we_addr.push_back(bus.IM_Addr);
            we_data.push_back(bus.IM_WD);
            $display("write: addr=%h data=%h", bus.IM_Addr, bus.IM_WD);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.Byte_In    = b;
        bus.Byte_Valid = 1'b1;
        while (bus.Byte_Ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        tick();
        bus.Byte_Valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] len);
        Start    = 1'b1;
        Load_Len = len;
        tick();
        Start    = 1'b0;
    endtask

    // Called with the final payload WRITE visible; leaves the block in DONE/ERR.
    task automatic finish_load(input logic [7:0] chk);
`ifdef LOADER_CHECKSUM_EN
        tick();
        check("chk_wait_ready", {31'd0, bus.Byte_Ready}, 32'd1);
        send_byte(chk);
`else
        if (chk === 8'hxx) check("chk_unused", 32'd0, 32'd1);
        tick();
`endif
    endtask

    initial begin
        bus.Byte_In    = '0;
        bus.Byte_Valid = 1'b0;

        // Reset state
        tick();
        check("rst_flags", {26'd0, bus.Byte_Ready, bus.IM_WE, CPU_RST, Busy, Done, Error}, 32'd0);
        check("rst_addr", bus.IM_Addr, 32'd0);
        check("rst_wd", bus.IM_WD, 32'd0);
        RST = 1'b1;
        tick();

        // Two-word load, no stalls
        base = we_addr.size();
        do_start(16'd2);
        check("start_busy", {30'd0, Busy, bus.Byte_Ready}, 32'd3);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check("w0_we", {31'd0, bus.IM_WE}, 32'd1);
        check("w0_addr", bus.IM_Addr, 32'd0);
        check("w0_wd", bus.IM_WD, 32'h2008_0005);
        send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        check("w1_addr", bus.IM_Addr, 32'd4);
        check("w1_wd", bus.IM_WD, 32'hAC08_0000);
        finish_load(8'h89);
        check("load2_done", {28'd0, Done, CPU_RST, Busy, Error}, 32'hC);
        check("load2_we_count", we_addr.size() - base, 32'd2);

        // Reload from DONE, with a stall and an ignored Start mid-word
        base = we_addr.size();
        do_start(16'd1);
        check("reload_cpu_rst", {30'd0, CPU_RST, Busy}, 32'd1);
        send_byte(8'h20); send_byte(8'h08);
        Start    = 1'b1;
        Load_Len = 16'd0;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("stall_flags", {29'd0, Busy, bus.Byte_Ready, Error}, 32'd6);
        check("stall_no_we", we_addr.size() - base, 32'd0);
        send_byte(8'h00); send_byte(8'h05);
        check("stall_addr", bus.IM_Addr, 32'd0);
        check("stall_wd", bus.IM_WD, 32'h2008_0005);
        finish_load(8'h2D);
        check("stall_done", {31'd0, Done}, 32'd1);

        // Full-depth load: last address is 4*(DEPTH-1)
        base = we_addr.size();
        do_start(16'd100);
        check("depth_busy", {30'd0, Busy, Error}, 32'd2);
        for (int w = 0; w < 100; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(w));
        end
        check("depth_last_addr", bus.IM_Addr, 32'd396);
        check("depth_last_wd", bus.IM_WD, 32'h6363_6363);
        finish_load(8'h00);
        check("depth_done", {31'd0, Done}, 32'd1);
        check("depth_we_count", we_addr.size() - base, 32'd100);
        check("depth_w37", we_data[base + 37], 32'h2525_2525);

        // Invalid lengths
        base = we_addr.size();
        do_start(16'd0);
        check("len0_flags", {28'd0, Error, CPU_RST, Busy, Done}, 32'h8);
        do_start(16'd101);
        check("len101_flags", {28'd0, Error, CPU_RST, Busy, Done}, 32'h8);
        check("badlen_no_we", we_addr.size() - base, 32'd0);

        // Reset mid-load after 6 of 8 bytes
        base = we_addr.size();
        do_start(16'd2);
        send_byte(8'h11); send_byte(8'h12); send_byte(8'h13); send_byte(8'h14);
        send_byte(8'h15); send_byte(8'h16);
        check("pre_rst_we", we_addr.size() - base, 32'd1);
        RST = 1'b0;
        #1;
        check("midrst_flags", {26'd0, bus.Byte_Ready, bus.IM_WE, CPU_RST, Busy, Done, Error}, 32'd0);
        check("midrst_addr_wd", bus.IM_Addr | bus.IM_WD, 32'd0);
        tick();
        RST = 1'b1;
        tick();
        do_start(16'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("postrst_addr", bus.IM_Addr, 32'd0);
        check("postrst_wd", bus.IM_WD, 32'hAABB_CCDD);
        finish_load(8'h00);
        check("postrst_done", {31'd0, Done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        do_start(16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        finish_load(8'h0F);
        check("chk_good", {30'd0, Done, Error}, 32'd2);
        do_start(16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        finish_load(8'h0E);
        check("chk_bad", {30'd0, Done, Error}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
